// File: rtl/bsg_rr_arb_input_fifos_p3.sv
// Three per-requester FIFOs feeding a 3-input round-robin arbiter.
// Each FIFO's occupancy drives the arbiter's request vector. The granted
// channel's head is dequeued, and the head selected by the arbiter tag is
// presented on data_o.
module bsg_rr_arb_input_fifos_p3 #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [2:0]                            v_i,
    input  logic [3*width_p-1:0]                  data_i,
    output logic [2:0]                            ready_o,
    output logic [2:0]                            reqs_o,
    input  logic [2:0]                            grants_i,
    input  logic [1:0]                            tag_i,
    output logic [width_p-1:0]                    data_o,
    output logic [3*$clog2(els_p+1)-1:0]          count_o,
    output logic                                  error_o
);

    localparam int unsigned chans_lp     = 3;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
    localparam int unsigned ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]      mem_r   [chans_lp][els_p];
    logic [ptr_width_lp-1:0] wptr_r  [chans_lp];
    logic [ptr_width_lp-1:0] rptr_r  [chans_lp];
    logic [cnt_width_lp-1:0] count_r [chans_lp];
    logic                    error_r;

    logic [2:0] not_full;
    logic [2:0] not_empty;
    logic [2:0] enq;
    logic [2:0] deq;
    logic       proto_err;

    // Per-channel handshake decode from registered occupancy.
    always_comb begin
        not_full  = '0;
        not_empty = '0;
        count_o   = '0;
        for (int k = 0; k < chans_lp; k++) begin
            not_full[k]  = (count_r[k] != cnt_width_lp'(els_p));
            not_empty[k] = (count_r[k] != '0);
            count_o[k*cnt_width_lp +: cnt_width_lp] = count_r[k];
        end
    end

    // Ready is withheld while reset is asserted so nothing is accepted.
    always_comb begin
        ready_o = not_full & {3{reset_n_i}};
        reqs_o  = not_empty;
        enq     = v_i & ready_o;
        deq     = grants_i & not_empty;
        error_o = error_r;
    end

    // Head of the tagged FIFO, zero when the tag is out of range or it is empty.
    always_comb begin
        data_o = '0;
        if (tag_i != 2'd3 && not_empty[tag_i]) begin
            data_o = mem_r[tag_i][rptr_r[tag_i]];
        end
    end

    // Arbiter-side protocol violations: multi-hot grant, grant without request,
    // or a grant paired with the unused tag value.
    always_comb begin
        proto_err = 1'b0;
        if ((grants_i & (grants_i - 3'd1)) != 3'd0) proto_err = 1'b1;
        if ((grants_i & ~not_empty) != 3'd0)         proto_err = 1'b1;
        if (tag_i == 2'd3 && grants_i != 3'd0)       proto_err = 1'b1;
    end

    // Pointers, occupancy and sticky error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < chans_lp; k++) begin
                wptr_r[k]  <= '0;
                rptr_r[k]  <= '0;
                count_r[k] <= '0;
            end
            error_r <= 1'b0;
        end else begin
            for (int k = 0; k < chans_lp; k++) begin
                if (enq[k]) wptr_r[k] <= wptr_r[k] + ptr_width_lp'(1);
                if (deq[k]) rptr_r[k] <= rptr_r[k] + ptr_width_lp'(1);
                count_r[k] <= count_r[k] + cnt_width_lp'(enq[k]) - cnt_width_lp'(deq[k]);
            end
            if (proto_err) error_r <= 1'b1;
        end
    end

    // Payload storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < chans_lp; k++) begin
            if (enq[k]) mem_r[k][wptr_r[k]] <= data_i[k*width_p +: width_p];
        end
    end

endmodule
